// File: rtl/nibble_assembler_pkg.sv
// Shared definitions for hex digit entry: nibble width, entry FSM states,
// and the per-cycle action priority used by display and entry blocks.
package nibble_assembler_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_CLEAR  = 3'd1,
        ACT_COMMIT = 3'd2,
        ACT_BACK   = 3'd3,
        ACT_NIB    = 3'd4
    } action_t;

    // Exactly one action per cycle; lower-priority strobes are dropped.
    function automatic action_t decode_action(
        input logic clear,
        input logic commit,
        input logic back,
        input logic nib_valid
    );
        if (clear)          return ACT_CLEAR;
        else if (commit)    return ACT_COMMIT;
        else if (back)      return ACT_BACK;
        else if (nib_valid) return ACT_NIB;
        else                return ACT_NONE;
    endfunction

endpackage

// File: rtl/nibble_assembler_shift_reg.sv
// Digit shift register: shift-left-in a nibble, shift-right with zero fill,
// synchronous clear (highest priority), asynchronous active-low reset.
module nibble_shift_reg
    import nibble_assembler_pkg::*;
#(
    parameter int unsigned DIGITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sync_clr,
    input  logic                      shift_in,
    input  logic                      shift_out,
    input  logic [NIB_W-1:0]          nib,
    output logic [NIB_W*DIGITS-1:0]   word
);

    localparam int unsigned WORD_W = NIB_W * DIGITS;

    // Truncating the concatenation drops the oldest digit without a slice,
    // which keeps DIGITS = 1 legal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word <= '0;
        end else if (sync_clr) begin
            word <= '0;
        end else if (shift_out) begin
            word <= word >> NIB_W;
        end else if (shift_in) begin
            word <= WORD_W'({word, nib});
        end
    end

endmodule

// File: rtl/nibble_assembler.sv
// Hex digit entry: assembles nibble strobes into a working word with
// backspace, clear and commit; publishes a one-cycle-valid result word.
module nibble_assembler
    import nibble_assembler_pkg::*;
#(
    parameter int unsigned DIGITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NIB_W-1:0]          nib_in,
    input  logic                      nib_valid,
    input  logic                      back,
    input  logic                      clear,
    input  logic                      commit,
    output logic [NIB_W*DIGITS-1:0]   work_word,
    output logic [3:0]                digit_cnt,
    output logic                      full,
    output logic                      overflow,
    output logic [NIB_W*DIGITS-1:0]   result,
    output logic                      result_valid
);

    localparam int unsigned WORD_W  = NIB_W * DIGITS;
    localparam logic [3:0]  CNT_MAX = 4'(DIGITS);

    state_t              state;
    state_t              state_next;
    action_t             act;
    logic [3:0]          cnt_next;
    logic                do_clr;
    logic                do_shl;
    logic                do_shr;
    logic                ovf_next;
    logic                rv_next;
    logic [WORD_W-1:0]   res_next;

    assign act = decode_action(clear, commit, back, nib_valid);

    always_comb begin
        state_next = state;
        cnt_next   = digit_cnt;
        do_clr     = 1'b0;
        do_shl     = 1'b0;
        do_shr     = 1'b0;
        ovf_next   = 1'b0;
        rv_next    = 1'b0;
        res_next   = result;
        case (act)
            ACT_CLEAR: begin
                do_clr     = 1'b1;
                cnt_next   = '0;
                state_next = ST_EMPTY;
            end
            ACT_COMMIT: begin
                do_clr     = 1'b1;
                cnt_next   = '0;
                state_next = ST_EMPTY;
                rv_next    = 1'b1;
                res_next   = work_word;
            end
            ACT_BACK: begin
                if (state != ST_EMPTY) begin
                    do_shr     = 1'b1;
                    cnt_next   = digit_cnt - 4'd1;
                    state_next = (cnt_next == '0) ? ST_EMPTY : ST_PARTIAL;
                end
            end
            ACT_NIB: begin
                if (state == ST_FULL) begin
                    ovf_next = 1'b1;
                end else begin
                    do_shl     = 1'b1;
                    cnt_next   = digit_cnt + 4'd1;
                    state_next = (cnt_next == CNT_MAX) ? ST_FULL : ST_PARTIAL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_EMPTY;
            digit_cnt    <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            state        <= state_next;
            digit_cnt    <= cnt_next;
            overflow     <= ovf_next;
            result_valid <= rv_next;
            result       <= res_next;
        end
    end

    assign full = (state == ST_FULL);

    nibble_shift_reg #(
        .DIGITS (DIGITS)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .sync_clr  (do_clr),
        .shift_in  (do_shl),
        .shift_out (do_shr),
        .nib       (nib_in),
        .word      (work_word)
    );

endmodule

// File: tb/tb_nibble_assembler.sv
// Self-checking bench for nibble_assembler: directed scenarios plus random
// strobes against a digit-queue reference model.
module tb_nibble_assembler;

    localparam int DIGITS = 8;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   nib_in;
    logic         nib_valid;
    logic         back;
    logic         clear;
    logic         commit;
    logic [W-1:0] work_word;
    logic [3:0]   digit_cnt;
    logic         full;
    logic         overflow;
    logic [W-1:0] result;
    logic         result_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: entered digits oldest-first, plus last committed value.
    int unsigned  dq[$];
    logic [W-1:0] m_result;
    logic         m_rv;
    logic         m_ovf;

    nibble_assembler #(
        .DIGITS (DIGITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .nib_in       (nib_in),
        .nib_valid    (nib_valid),
        .back         (back),
        .clear        (clear),
        .commit       (commit),
        .work_word    (work_word),
        .digit_cnt    (digit_cnt),
        .full         (full),
        .overflow     (overflow),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] m_word();
        logic [W-1:0] w = '0;
        foreach (dq[i]) w = (w << 4) | W'(dq[i]);
        return w;
    endfunction

    // Drive one cycle of strobes, then advance the model by the same rules.
    task automatic act(input logic nv, input logic [3:0] d, input logic bk,
                       input logic cl, input logic cm);
        nib_valid = nv; nib_in = d; back = bk; clear = cl; commit = cm;
        @(posedge clk);
        #1;
        nib_valid = 1'b0; back = 1'b0; clear = 1'b0; commit = 1'b0;
        m_rv  = 1'b0;
        m_ovf = 1'b0;
        if (cl) begin
            dq.delete();
        end else if (cm) begin
            m_result = m_word();
            dq.delete();
            m_rv = 1'b1;
        end else if (bk) begin
            if (dq.size() > 0) void'(dq.pop_back());
        end else if (nv) begin
            if (dq.size() < DIGITS) dq.push_back(int'(d));
            else m_ovf = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; nib_in = '0; nib_valid = 0; back = 0; clear = 0; commit = 0;
        dq.delete(); m_result = '0; m_rv = 0; m_ovf = 0;
        #2;
        checks++;
        if (work_word !== '0) begin errors++; $display("FAIL reset_work got %h exp 0", work_word); end
        checks++;
        if (digit_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", digit_cnt); end
        checks++;
        if ({full, overflow, result_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {full, overflow, result_valid}); end
        checks++;
        if (result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) act(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        checks++;
        if (work_word !== 32'h12345678) begin errors++; $display("FAIL fill_work got %h exp 12345678", work_word); end
        checks++;
        if (digit_cnt !== 4'd8) begin errors++; $display("FAIL fill_cnt got %0d exp 8", digit_cnt); end
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    endtask

    task automatic test_overflow();
        act(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", overflow); end
        checks++;
        if (work_word !== 32'h12345678) begin errors++; $display("FAIL ovf_work got %h exp 12345678", work_word); end
        act(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got %b exp 0", overflow); end
        checks++;
        if (digit_cnt !== 4'd8) begin errors++; $display("FAIL ovf_cnt got %0d exp 8", digit_cnt); end
    endtask

    task automatic test_back();
        act(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        act(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        act(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
        act(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        act(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (work_word !== 32'h000000AB) begin errors++; $display("FAIL back_work got %h exp 000000ab", work_word); end
        checks++;
        if (digit_cnt !== 4'd2) begin errors++; $display("FAIL back_cnt got %0d exp 2", digit_cnt); end
        act(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        act(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (work_word !== '0 || digit_cnt !== 4'd0) begin errors++; $display("FAIL back_to_empty got %h/%0d exp 0/0", work_word, digit_cnt); end
        act(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (work_word !== '0 || digit_cnt !== 4'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL back_empty_noop got %h/%0d/%b exp 0/0/0", work_word, digit_cnt, overflow);
        end
    endtask

    task automatic test_commit();
        act(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        act(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        act(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        act(1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
        act(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (result !== 32'h0000F00D) begin errors++; $display("FAIL commit_result got %h exp 0000f00d", result); end
        checks++;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL commit_valid got %b exp 1", result_valid); end
        checks++;
        if (work_word !== '0 || digit_cnt !== 4'd0) begin errors++; $display("FAIL commit_clears got %h/%0d exp 0/0", work_word, digit_cnt); end
        act(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (result_valid !== 1'b0 || result !== 32'h0000F00D) begin
            errors++; $display("FAIL commit_hold got %b/%h exp 0/0000f00d", result_valid, result);
        end
    endtask

    task automatic test_priority();
        act(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        act(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        act(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        act(1'b1, 4'h5, 1'b0, 1'b1, 1'b1);
        checks++;
        if (work_word !== '0 || digit_cnt !== 4'd0 || full !== 1'b0) begin
            errors++; $display("FAIL prio_clear got %h/%0d/%b exp 0/0/0", work_word, digit_cnt, full);
        end
        checks++;
        if (result !== m_result || result_valid !== 1'b0) begin
            errors++; $display("FAIL prio_result got %h/%b exp %h/0", result, result_valid, m_result);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) act(1'b1, 4'(i + 9), 1'b0, 1'b0, 1'b0);
        checks++;
        if (digit_cnt !== 4'd5) begin errors++; $display("FAIL areset_pre_cnt got %0d exp 5", digit_cnt); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (work_word !== '0 || digit_cnt !== 4'd0 || result !== '0) begin
            errors++; $display("FAIL areset_immediate got %h/%0d/%h exp 0/0/0", work_word, digit_cnt, result);
        end
        checks++;
        if ({full, overflow, result_valid} !== 3'b000) begin errors++; $display("FAIL areset_flags got %b exp 000", {full, overflow, result_valid}); end
        @(negedge clk);
        reset = 1'b1;
        dq.delete();
        m_result = '0;
        act(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        checks++;
        if (work_word !== 32'h7 || digit_cnt !== 4'd1) begin
            errors++; $display("FAIL areset_restart got %h/%0d exp 00000007/1", work_word, digit_cnt);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_w;
        for (int n = 0; n < 400; n++) begin
            act($urandom_range(0, 1) == 0, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 14) == 0);
            exp_w = m_word();
            checks++;
            if (work_word !== exp_w) begin errors++; $display("FAIL rnd_work[%0d] got %h exp %h", n, work_word, exp_w); end
            checks++;
            if (digit_cnt !== 4'(dq.size())) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", n, digit_cnt, dq.size()); end
            checks++;
            if (full !== (dq.size() == DIGITS)) begin errors++; $display("FAIL rnd_full[%0d] got %b exp %b", n, full, dq.size() == DIGITS); end
            checks++;
            if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got %b exp %b", n, overflow, m_ovf); end
            checks++;
            if (result !== m_result || result_valid !== m_rv) begin
                errors++; $display("FAIL rnd_result[%0d] got %h/%b exp %h/%b", n, result, result_valid, m_result, m_rv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_back();
        test_commit();
        test_priority();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
